beat_scheduler: RTL and testbench

- Sequences gameplay during the play phase: walks a beatmap ROM, times each beat in video frames, and issues a one-cycle spawn pulse with a circle type.
- Judges the player's key press against the expected key within a hit window, and counts hits and misses.
- Produces the playerpass verdict and a done flag that the top-level screen state machine consumes.
- Sits between the frame-tick source and beatmap ROM on one side, and the screen FSM and circle sprite logic on the other.

---
 rtl/beat_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_beat_scheduler.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_scheduler.sv
// rtl/beat_scheduler.sv - play-phase beat sequencer: walks the beatmap, spawns circles, judges key presses.
module beat_scheduler #(
    parameter int NUM_BEATS      = 16,
    parameter int BEAT_INTERVAL  = 30,
    parameter int HIT_WINDOW     = 8,
    parameter int PASS_THRESHOLD = 12,
    parameter int ADDR_W         = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic              start,
    input  logic [7:0]        keycode,
    output logic [ADDR_W-1:0] map_addr,
    input  logic [2:0]        map_data,
    output logic              spawn,
    output logic [1:0]        circletype,
    output logic              hit,
    output logic              miss,
    output logic [7:0]        hits,
    output logic [7:0]        misses,
    output logic              busy,
    output logic              done,
    output logic              playerpass
);
    localparam int FC_W = $clog2(BEAT_INTERVAL + 1);
    localparam logic [7:0] KEY_QUIT = 8'h14;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_SPAWN, S_WINDOW, S_GAP, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] beat_idx_q, beat_idx_d;
    logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [7:0]        prev_key_q, prev_key_d;
    logic [7:0]        hits_q, hits_d;
    logic [7:0]        misses_q, misses_d;
    logic [1:0]        circletype_q, circletype_d;
    logic              spawn_q, spawn_d;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;
    logic              quit_q, quit_d;

    logic       press;
    logic [7:0] expected_key;

    assign press = (keycode != 8'h00) && (keycode != prev_key_q);

    always_comb begin
        expected_key = 8'h04;
        case (circletype_q)
            2'b00: expected_key = 8'h04;
            2'b01: expected_key = 8'h16;
            2'b10: expected_key = 8'h07;
            2'b11: expected_key = 8'h09;
            default: expected_key = 8'h04;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        beat_idx_d   = beat_idx_q;
        frame_cnt_d  = frame_cnt_q;
        prev_key_d   = keycode;
        hits_d       = hits_q;
        misses_d     = misses_q;
        circletype_d = circletype_q;
        quit_d       = quit_q;
        spawn_d      = 1'b0;
        hit_d        = 1'b0;
        miss_d       = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    hits_d     = 8'd0;
                    misses_d   = 8'd0;
                    beat_idx_d = '0;
                    quit_d     = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LATCH;
            S_LATCH: begin
                frame_cnt_d = '0;
                if (map_data[2]) begin
                    circletype_d = map_data[1:0];
                    spawn_d      = 1'b1;
                    state_d      = S_SPAWN;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_SPAWN: begin
                frame_cnt_d = '0;
                state_d     = S_WINDOW;
            end
            S_WINDOW: begin
                if (frame_tick)
                    frame_cnt_d = frame_cnt_q + FC_W'(1);
                // A press on the expiring tick is still judged as a press.
                if (press && keycode == expected_key) begin
                    hit_d   = 1'b1;
                    hits_d  = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
                    state_d = S_GAP;
                end else if (press || (frame_tick && frame_cnt_q == FC_W'(HIT_WINDOW - 1))) begin
                    miss_d   = 1'b1;
                    misses_d = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                if (frame_tick) begin
                    if (frame_cnt_q == FC_W'(BEAT_INTERVAL - 1)) begin
                        frame_cnt_d = '0;
                        if (beat_idx_q == ADDR_W'(NUM_BEATS - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            beat_idx_d = beat_idx_q + ADDR_W'(1);
                            state_d    = S_FETCH;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + FC_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Quitting abandons the beat in flight: nothing from this cycle is scored.
        if (keycode == KEY_QUIT && state_q != S_IDLE && state_q != S_DONE) begin
            state_d  = S_DONE;
            quit_d   = 1'b1;
            spawn_d  = 1'b0;
            hit_d    = 1'b0;
            miss_d   = 1'b0;
            hits_d   = hits_q;
            misses_d = misses_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            beat_idx_q   <= '0;
            frame_cnt_q  <= '0;
            prev_key_q   <= 8'd0;
            hits_q       <= 8'd0;
            misses_q     <= 8'd0;
            circletype_q <= 2'b00;
            spawn_q      <= 1'b0;
            hit_q        <= 1'b0;
            miss_q       <= 1'b0;
            quit_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_idx_q   <= beat_idx_d;
            frame_cnt_q  <= frame_cnt_d;
            prev_key_q   <= prev_key_d;
            hits_q       <= hits_d;
            misses_q     <= misses_d;
            circletype_q <= circletype_d;
            spawn_q      <= spawn_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
            quit_q       <= quit_d;
        end
    end

    assign map_addr   = beat_idx_q;
    assign spawn      = spawn_q;
    assign circletype = circletype_q;
    assign hit        = hit_q;
    assign miss       = miss_q;
    assign hits       = hits_q;
    assign misses     = misses_q;
    assign done       = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE) && (state_q != S_DONE);
    assign playerpass = done && (hits_q >= 8'(PASS_THRESHOLD)) && !quit_q;

endmodule

// File: tb/tb_beat_scheduler.sv
// tb/tb_beat_scheduler.sv - self-checking bench for beat_scheduler: directed beat table plus random runs.
module tb_beat_scheduler;
    localparam int NB = 4;
    localparam int BI = 4;
    localparam int HW = 2;
    localparam int PT = 3;
    localparam int TICK_GAP = 4;

    logic       Clk = 1'b0;
    logic       Reset, frame_tick, start;
    logic [7:0] keycode;
    logic [7:0] map_addr;
    logic [2:0] map_data;
    logic       spawn, hit, miss, busy, done, playerpass;
    logic [1:0] circletype;
    logic [7:0] hits, misses;

    logic [2:0] rom [0:NB-1];

    int checks = 0;
    int errors = 0;
    int n_spawn = 0, n_hit = 0, n_miss = 0;

    typedef struct {
        int         b;
        logic [7:0] hold;
        logic [7:0] k1;
        int         o1;
        logic [7:0] k2;
        int         o2;
        int         eh;
        int         em;
        bit         last;
    } vec_t;

    vec_t tbl[$];

    beat_scheduler #(
        .NUM_BEATS(NB), .BEAT_INTERVAL(BI), .HIT_WINDOW(HW), .PASS_THRESHOLD(PT), .ADDR_W(8)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .start(start), .keycode(keycode),
        .map_addr(map_addr), .map_data(map_data), .spawn(spawn), .circletype(circletype),
        .hit(hit), .miss(miss), .hits(hits), .misses(misses), .busy(busy), .done(done),
        .playerpass(playerpass)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) map_data <= rom[map_addr[1:0]];

    always @(negedge Clk) begin
        if (spawn) n_spawn <= n_spawn + 1;
        if (hit)   n_hit   <= n_hit + 1;
        if (miss)  n_miss  <= n_miss + 1;
    end

    function automatic logic [7:0] exp_key(input logic [1:0] t);
        case (t)
            2'b00:   return 8'h04;
            2'b01:   return 8'h16;
            2'b10:   return 8'h07;
            default: return 8'h09;
        endcase
    endfunction

    function automatic vec_t mk(input int b, input logic [7:0] hold, input logic [7:0] k1, input int o1,
                                input logic [7:0] k2, input int o2, input int eh, input int em, input bit last);
        vec_t v;
        v.b = b; v.hold = hold; v.k1 = k1; v.o1 = o1; v.k2 = k2; v.o2 = o2;
        v.eh = eh; v.em = em; v.last = last;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Entered on the negedge where this beat's trigger (start or previous final tick) is driven.
    // Frame ticks land every TICK_GAP cycles, so the beat ends on the cycle-16 tick.
    task automatic run_beat(input vec_t v, input int rst_off, output bit aborted);
        int  h0, m0, s0;
        bit  note;
        aborted = 1'b0;
        note = rom[v.b][2];
        h0 = n_hit; m0 = n_miss; s0 = n_spawn;
        for (int c = 1; c <= BI * TICK_GAP; c++) begin
            @(negedge Clk);
            start      = 1'b0;
            frame_tick = (c % TICK_GAP == 0);
            keycode    = v.hold;
            if (c == v.o1) keycode = v.k1;
            if (c == v.o2) keycode = v.k2;
            if (c == 1) begin
                chk("map_addr", map_addr, v.b);
                chk("busy_in_run", busy, 1);
                chk("done_in_run", done, 0);
                if (v.b == 0) begin
                    chk("hits_cleared", hits, 0);
                    chk("misses_cleared", misses, 0);
                end
            end
            if (c == 3) begin
                chk("spawn_at_3", spawn, note);
                if (note) chk("circletype", circletype, rom[v.b][1:0]);
            end
            if (v.k2 == 8'h14 && c == v.o2 + 1) begin
                chk("quit_done", done, 1);
                chk("quit_pass", playerpass, 0);
            end
            if (c == rst_off) begin
                Reset = 1'b1;
                start = 1'b1;
                keycode = 8'h00;
                frame_tick = 1'b0;
                aborted = 1'b1;
                return;
            end
        end
        chk("beat_hits", n_hit - h0, v.eh);
        chk("beat_misses", n_miss - m0, v.em);
        chk("beat_spawns", n_spawn - s0, int'(note));
    endtask

    task automatic end_run(input int eh, input int em, input bit quit);
        @(negedge Clk);
        frame_tick = 1'b0;
        keycode    = 8'h00;
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_hits", hits, eh);
        chk("end_misses", misses, em);
        chk("end_pass", playerpass, int'((eh >= PT) && !quit));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_spawn"}, spawn, 0);
        chk({tag, "_hit"}, hit, 0);
        chk({tag, "_miss"}, miss, 0);
        chk({tag, "_hits"}, hits, 0);
        chk({tag, "_misses"}, misses, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_pass"}, playerpass, 0);
        chk({tag, "_addr"}, map_addr, 0);
        chk({tag, "_ctype"}, circletype, 0);
    endtask

    task automatic play_vec(input vec_t v, inout int sh, inout int sm, inout bit q);
        bit ab;
        if (v.b == 0) begin
            start = 1'b1; keycode = 8'h00; frame_tick = 1'b0;
            sh = 0; sm = 0; q = 1'b0;
        end
        run_beat(v, 0, ab);
        sh += v.eh;
        sm += v.em;
        if (v.k1 == 8'h14 || v.k2 == 8'h14) q = 1'b1;
        if (v.last) end_run(sh, sm, q);
    endtask

    initial begin
        int  sh, sm;
        bit  q, ab;
        vec_t v;

        rom[0] = 3'b100; rom[1] = 3'b101; rom[2] = 3'b000; rom[3] = 3'b111;
        Reset = 1'b1; start = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
        sh = 0; sm = 0; q = 1'b0;

        // all hits, incl. a press on the expiring tick
        tbl.push_back(mk(0, 8'h00, 8'h04, 5, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h00, 8'h16, 6, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(2, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(3, 8'h00, 8'h09, 8, 8'h00, 0, 1, 0, 1));
        // no presses at all
        tbl.push_back(mk(0, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(2, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(3, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 1));
        // wrong key then right key, late press, press on rest beat, press on first tick
        tbl.push_back(mk(0, 8'h00, 8'h07, 4, 8'h04, 6, 0, 1, 0));
        tbl.push_back(mk(1, 8'h00, 8'h16, 10, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(2, 8'h00, 8'h04, 5, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(3, 8'h00, 8'h09, 4, 8'h00, 0, 1, 0, 1));
        // quit mid-window of beat 1
        tbl.push_back(mk(0, 8'h00, 8'h04, 5, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h00, 8'h00, 0, 8'h14, 6, 0, 0, 1));
        // enough hits, then quit in the last gap: verdict must still fail
        tbl.push_back(mk(0, 8'h00, 8'h04, 5, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(1, 8'h00, 8'h16, 5, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(2, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(3, 8'h00, 8'h09, 5, 8'h14, 10, 1, 0, 1));
        // key held across beats never forms a new press
        tbl.push_back(mk(0, 8'h04, 8'h04, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(1, 8'h04, 8'h04, 0, 8'h00, 0, 0, 1, 0));
        tbl.push_back(mk(2, 8'h00, 8'h00, 0, 8'h00, 0, 0, 0, 0));
        tbl.push_back(mk(3, 8'h00, 8'h09, 5, 8'h00, 0, 1, 0, 1));

        repeat (2) @(negedge Clk);
        check_all_zero("reset");
        Reset = 1'b0;
        @(negedge Clk);
        check_all_zero("idle");

        foreach (tbl[i]) play_vec(tbl[i], sh, sm, q);

        // Reset in beat 1's gap, on the cycle its miss pulse is showing
        start = 1'b1;
        run_beat(tbl[0], 0, ab);
        run_beat(mk(1, 8'h00, 8'h00, 0, 8'h00, 0, 0, 1, 0), 9, ab);
        chk("reset_abort", int'(ab), 1);
        @(negedge Clk);
        check_all_zero("midrun_reset");
        start = 1'b1;
        @(negedge Clk);
        Reset = 1'b0; start = 1'b0;
        @(negedge Clk);
        chk("start_in_reset_busy", busy, 0);
        chk("start_in_reset_done", done, 0);
        chk("start_in_reset_addr", map_addr, 0);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < NB; i++) rom[i] = 3'($urandom_range(0, 7));
            for (int b = 0; b < NB; b++) begin
                int         act, off, hit_e;
                logic [7:0] k, ek;
                act = $urandom_range(0, 2);
                off = $urandom_range(4, 15);
                ek  = exp_key(rom[b][1:0]);
                k   = 8'h00;
                if (act == 1) k = ek;
                if (act == 2) begin
                    do k = 8'($urandom_range(1, 255)); while (k == ek || k == 8'h14);
                end
                // judged only while fewer than HW ticks preceded the press
                hit_e = (rom[b][2] && act == 1 && ((off - 1) / TICK_GAP) < HW) ? 1 : 0;
                v = mk(b, 8'h00, k, (act == 0) ? 0 : off, 8'h00, 0,
                       hit_e, (rom[b][2] && hit_e == 0) ? 1 : 0, b == NB - 1);
                play_vec(v, sh, sm, q);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
